bram11_arbiter: RTL and testbench

- Owns the single port of the 11-word coefficient BRAM.
- Shares that port between two requesters:
  - the configuration requester (host/AXI-Lite side; reads and writes tap coefficients);
  - the engine requester (FIR datapath; read-only).
- After reset, sequences a zero-initialisation sweep of all words before granting anything.
- Arbitrates round-robin on conflict, returns read data with fixed latency and flags out-of-range accesses.

---
 rtl/bram11_arbiter.sv | 121 ++++++++++++
 tb/tb_bram11_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram11_arbiter.sv
// Single-port arbiter for the 11-word coefficient BRAM: zero-fills it after reset, then grants cfg/eng round-robin.
// Grants are same-cycle (combinational), read responses 1 cycle later; a losing requester just holds req.
module bram11_arbiter #(
  parameter int NUM_WORDS  = 11,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  init_done,
  input  logic                  cfg_req,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_wstrb,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_gnt,
  output logic                  cfg_rvalid,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  cfg_err,
  input  logic                  eng_req,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  output logic                  eng_gnt,
  output logic                  eng_rvalid,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  eng_err,
  output logic                  bram_EN,
  output logic [3:0]            bram_WE,
  output logic [ADDR_WIDTH-1:0] bram_A,
  output logic [DATA_WIDTH-1:0] bram_Di,
  input  logic [DATA_WIDTH-1:0] bram_Do
);

  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0]         LAST_CNT = CW'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-3:0] NWORDS   = (ADDR_WIDTH-2)'(NUM_WORDS);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  last_eng_q;
  logic                  init_done_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic                  cfg_rd_q, cfg_err_q, eng_rd_q, eng_err_q;

  logic                  run;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  in_range;

  assign run      = (state_q == ST_RUN);
  // Ties go to whoever was not granted last; last_eng_q resets to 1 so cfg wins the first tie.
  assign cfg_gnt  = run & cfg_req & (~eng_req | last_eng_q);
  assign eng_gnt  = run & eng_req & (~cfg_req | ~last_eng_q);
  assign any_gnt  = cfg_gnt | eng_gnt;
  assign sel_addr = cfg_gnt ? cfg_addr : eng_addr;
  assign in_range = (sel_addr[ADDR_WIDTH-1:2] < NWORDS);

  always_comb begin
    bram_EN = ~RST;
    bram_WE = 4'h0;
    bram_A  = a_q;
    bram_Di = cfg_wdata;
    if (state_q == ST_INIT) begin
      bram_WE = RST ? 4'h0 : 4'hF;
      bram_A  = ADDR_WIDTH'({cnt_q, 2'b00});
      bram_Di = '0;
    end else if (any_gnt) begin
      bram_A = in_range ? sel_addr : '0;
      if (cfg_gnt && cfg_we && in_range) begin
        bram_WE = cfg_wstrb;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      last_eng_q  <= 1'b1;
      init_done_q <= 1'b0;
      a_q         <= '0;
      cfg_rd_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      eng_rd_q    <= 1'b0;
      eng_err_q   <= 1'b0;
    end else begin
      a_q <= bram_A;
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (any_gnt) begin
            last_eng_q <= eng_gnt;
          end
        end
        default: state_q <= ST_INIT;
      endcase
      cfg_rd_q  <= cfg_gnt & ~cfg_we;
      cfg_err_q <= cfg_gnt & ~in_range;
      eng_rd_q  <= eng_gnt;
      eng_err_q <= eng_gnt & ~in_range;
    end
  end

  assign init_done  = init_done_q;
  assign cfg_rvalid = cfg_rd_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_rdata  = (cfg_rd_q & ~cfg_err_q) ? bram_Do : '0;
  assign eng_rvalid = eng_rd_q;
  assign eng_err    = eng_err_q;
  assign eng_rdata  = (eng_rd_q & ~eng_err_q) ? bram_Do : '0;

endmodule

// File: tb/tb_bram11_arbiter.sv
// Bench for bram11_arbiter: directed requests feed per-requester expectation queues that a negedge monitor drains.
module tb_bram11_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_done;
  logic        cfg_req = 1'b0, cfg_we = 1'b0;
  logic [3:0]  cfg_wstrb = 4'h0;
  logic [11:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_gnt, cfg_rvalid, cfg_err;
  logic [31:0] cfg_rdata;
  logic        eng_req = 1'b0;
  logic [11:0] eng_addr = '0;
  logic        eng_gnt, eng_rvalid, eng_err;
  logic [31:0] eng_rdata;
  logic        bram_EN;
  logic [3:0]  bram_WE;
  logic [11:0] bram_A;
  logic [31:0] bram_Di, bram_Do;

  bram11_arbiter dut (
    .CLK(CLK), .RST(RST), .init_done(init_done),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_wstrb(cfg_wstrb), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .cfg_err(cfg_err), .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata), .eng_err(eng_err),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_A(bram_A), .bram_Di(bram_Di), .bram_Do(bram_Do)
  );

  always #5 CLK = ~CLK;

  // BRAM model: registered address, byte-masked writes, Do gated by EN.
  logic [31:0] mem [0:15];
  logic [31:0] do_q = '0;
  bit          seeded = 1'b0;
  always @(posedge CLK) begin
    if (RST && !seeded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hBAD0_0000 + i;
      seeded <= 1'b1;
    end else if (bram_EN) begin
      do_q <= mem[bram_A[5:2]];
      for (int b = 0; b < 4; b++)
        if (bram_WE[b]) mem[bram_A[5:2]][8*b +: 8] <= bram_Di[8*b +: 8];
    end
  end
  assign bram_Do = bram_EN ? do_q : 32'h0;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t cfg_q[$];
  exp_t eng_q[$];

  // Monitor: every response must match the queue head, in the cycle after its grant.
  exp_t ce, ee;
  always @(negedge CLK) begin
    if (!RST) begin
      if (cfg_rvalid || cfg_err) begin
        if (cfg_q.size() == 0) note_fail("cfg_unexpected_response");
        else begin
          ce = cfg_q.pop_front();
          chk("cfg_rsp_cycle", cyc, ce.cyc);
          chk("cfg_rvalid", cfg_rvalid, ce.rd);
          chk("cfg_rdata", cfg_rdata, ce.data);
          chk("cfg_err", cfg_err, ce.err);
        end
      end else begin
        if (cfg_q.size() != 0 && cfg_q[0].cyc <= cyc) begin
          void'(cfg_q.pop_front());
          note_fail("cfg_response_missing");
        end
        chk("cfg_rdata_idle", cfg_rdata, 32'h0);
      end
      if (eng_rvalid || eng_err) begin
        if (eng_q.size() == 0) note_fail("eng_unexpected_response");
        else begin
          ee = eng_q.pop_front();
          chk("eng_rsp_cycle", cyc, ee.cyc);
          chk("eng_rvalid", eng_rvalid, ee.rd);
          chk("eng_rdata", eng_rdata, ee.data);
          chk("eng_err", eng_err, ee.err);
        end
      end else begin
        if (eng_q.size() != 0 && eng_q[0].cyc <= cyc) begin
          void'(eng_q.pop_front());
          note_fail("eng_response_missing");
        end
        chk("eng_rdata_idle", eng_rdata, 32'h0);
      end
      if (cfg_gnt && eng_gnt) note_fail("both_granted");
    end
  end

  task automatic cfg_op(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_d, output int gc);
    int   n;
    logic oor;
    exp_t e;
    oor = (addr >> 2) >= 11;
    cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd; cfg_wstrb = st;
    n = 0;
    gc = -1;
    do begin @(negedge CLK); n++; end while (!cfg_gnt && n < 40);
    if (!cfg_gnt) note_fail("cfg_grant_timeout");
    else begin
      gc = cyc;
      chk("cfg_bram_A", bram_A, oor ? 12'h0 : addr);
      chk("cfg_bram_WE", bram_WE, (we && !oor) ? st : 4'h0);
      if (we) chk("cfg_bram_Di", bram_Di, wd);
      if (!we || oor) begin
        e.rd = !we; e.data = (we || oor) ? 32'h0 : exp_d; e.err = oor; e.cyc = cyc + 1;
        cfg_q.push_back(e);
      end
    end
    @(posedge CLK); #1;
    cfg_req = 1'b0;
  endtask

  task automatic eng_op(input logic [11:0] addr, input logic [31:0] exp_d, output int gc);
    int   n;
    logic oor;
    exp_t e;
    oor = (addr >> 2) >= 11;
    eng_req = 1'b1; eng_addr = addr;
    n = 0;
    gc = -1;
    do begin @(negedge CLK); n++; end while (!eng_gnt && n < 40);
    if (!eng_gnt) note_fail("eng_grant_timeout");
    else begin
      gc = cyc;
      chk("eng_bram_A", bram_A, oor ? 12'h0 : addr);
      chk("eng_bram_WE", bram_WE, 4'h0);
      e.rd = 1'b1; e.data = oor ? 32'h0 : exp_d; e.err = oor; e.cyc = cyc + 1;
      eng_q.push_back(e);
    end
    @(posedge CLK); #1;
    eng_req = 1'b0;
  endtask

  // Call just after reset release; cfg_req is expected to be held (read) throughout.
  task automatic init_sweep(input int ncyc, input logic expect_grant, input logic [31:0] exp_d);
    exp_t e;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      chk("init_bram_A", bram_A, 12'(i * 4));
      chk("init_bram_WE", bram_WE, 4'hF);
      chk("init_bram_EN", bram_EN, 1'b1);
      chk("init_bram_Di", bram_Di, 32'h0);
      chk("init_done_low", init_done, 1'b0);
      chk("init_no_gnt", {cfg_gnt, eng_gnt}, 2'b00);
    end
    if (expect_grant) begin
      @(negedge CLK);
      chk("init_done_rise", init_done, 1'b1);
      chk("first_run_cfg_gnt", cfg_gnt, 1'b1);
      if (cfg_gnt) begin
        e.rd = 1'b1; e.data = exp_d; e.err = 1'b0; e.cyc = cyc + 1;
        cfg_q.push_back(e);
      end
      @(posedge CLK); #1;
      cfg_req = 1'b0;
    end
  endtask

  task automatic check_in_reset();
    @(negedge CLK);
    chk("rst_bram_EN", bram_EN, 1'b0);
    chk("rst_bram_WE", bram_WE, 4'h0);
    chk("rst_bram_A", bram_A, 12'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_gnt", {cfg_gnt, eng_gnt}, 2'b00);
    chk("rst_rsp", {cfg_rvalid, cfg_err, eng_rvalid, eng_err}, 4'h0);
  endtask

  initial begin
    int c1, c2, e1, e2, g;
    // Reset, with a config read of word 0 held from cycle 0.
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 12'h000;
    check_in_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    init_sweep(11, 1'b1, 32'h0);

    // Write then engine read of the same word on the next cycle.
    cfg_op(1'b1, 12'h000, 32'hA5A5_0001, 4'hF, 32'h0, g);
    cfg_op(1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, 32'h0, c1);
    eng_op(12'h008, 32'hDEAD_BEEF, e1);
    chk("wr_rd_next_cycle", e1, c1 + 1);

    // Both requesting for four cycles: grants must alternate cfg, eng, cfg, eng.
    fork
      begin
        cfg_op(1'b0, 12'h008, 32'h0, 4'h0, 32'hDEAD_BEEF, c1);
        cfg_op(1'b0, 12'h000, 32'h0, 4'h0, 32'hA5A5_0001, c2);
      end
      begin
        eng_op(12'h000, 32'hA5A5_0001, e1);
        eng_op(12'h008, 32'hDEAD_BEEF, e2);
      end
    join
    chk("rr_eng_first", e1, c1 + 1);
    chk("rr_cfg_second", c2, c1 + 2);
    chk("rr_eng_second", e2, c1 + 3);

    // Out-of-range write is dropped and flagged; last word keeps its value.
    cfg_op(1'b1, 12'h028, 32'h5555_AAAA, 4'hF, 32'h0, g);
    cfg_op(1'b1, 12'h02C, 32'h0000_1234, 4'hF, 32'h0, g);
    cfg_op(1'b0, 12'h028, 32'h0, 4'h0, 32'h5555_AAAA, g);
    cfg_op(1'b0, 12'h040, 32'h0, 4'h0, 32'h0, g);
    eng_op(12'hFFC, 32'h0, g);
    eng_op(12'h02C, 32'h0, g);

    // Byte strobes, including an all-zero strobe.
    cfg_op(1'b1, 12'h004, 32'h1122_3344, 4'hF, 32'h0, g);
    cfg_op(1'b1, 12'h004, 32'hAABB_CCDD, 4'b0010, 32'h0, g);
    cfg_op(1'b0, 12'h004, 32'h0, 4'h0, 32'h1122_CC44, g);
    cfg_op(1'b1, 12'h004, 32'hFFFF_FFFF, 4'h0, 32'h0, g);
    eng_op(12'h004, 32'h1122_CC44, g);

    // Idle RUN cycle: address holds, no write, enable stays on.
    @(negedge CLK);
    chk("idle_bram_A_hold", bram_A, 12'h004);
    chk("idle_bram_WE", bram_WE, 4'h0);
    chk("idle_bram_EN", bram_EN, 1'b1);
    repeat (2) @(negedge CLK);

    // Reset, partial sweep of 5 words, reset again, then a full sweep from word 0.
    @(posedge CLK); #1;
    RST = 1'b1;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 12'h004;
    check_in_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    init_sweep(5, 1'b0, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    check_in_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    init_sweep(11, 1'b1, 32'h0);

    repeat (3) @(negedge CLK);
    chk("cfg_queue_drained", cfg_q.size(), 0);
    chk("eng_queue_drained", eng_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
